// File: rtl/lock_pkg.sv
// Shared definitions for the push-button lock session controller.
// Holds the state encoding seen by the seven-segment decoder, the
// power-on code, and the helper that sizes the shared second timer.
package lock_pkg;

    // Values are visible on state_code, so they must not be renumbered.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_PROG    = 3'd3,
        ST_LOCKOUT = 3'd4
    } lock_state_t;

    localparam logic [4:0] DEFAULT_CODE = 5'b11011;

    // One spare bit above clog2 so the largest load value always fits.
    function automatic int timer_width(input int a, input int b, input int c);
        int largest;
        largest = a;
        if (b > largest) largest = b;
        if (c > largest) largest = c;
        return $clog2(largest) + 1;
    endfunction

endpackage

// File: rtl/lock_sequencer_if.sv
// Operator-side signal bundle of the lock session controller.
// master: drives the button pulses and reads the lock status.
// slave:  the controller itself.
//   bit_zero / bit_one / prog_req : one-cycle pulses from the synchronizers
//   unlock, alarm                 : actuator enable and lockout indicator
//   state_code, digit_cnt         : state and captured-bit count for display
//   fail_cnt                      : consecutive failed attempts
interface lock_sequencer_if;
    logic       bit_zero;
    logic       bit_one;
    logic       prog_req;
    logic       unlock;
    logic       alarm;
    logic [2:0] state_code;
    logic [2:0] digit_cnt;
    logic [1:0] fail_cnt;

    modport master (
        output bit_zero, bit_one, prog_req,
        input  unlock, alarm, state_code, digit_cnt, fail_cnt
    );

    modport slave (
        input  bit_zero, bit_one, prog_req,
        output unlock, alarm, state_code, digit_cnt, fail_cnt
    );
endinterface

// File: rtl/lock_sequencer_sec_timer.sv
// sec_timer: loadable down-counter shared by the unlock window, the
// lockout period and the entry timeout.
//   clk_1hz, reset : tick and asynchronous active-high reset
//   load, load_val : load a new period (takes priority over counting)
//   expired        : high during the last cycle of a loaded period
module sec_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clk_1hz,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);
    logic [WIDTH-1:0] count;

    // Counts down and parks at zero so an idle timer never re-fires.
    always_ff @(posedge clk_1hz or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    // Flagging at one means the edge that sees it is exactly load_val
    // cycles after the loading edge.
    assign expired = (count == WIDTH'(1));
endmodule

// File: rtl/lock_sequencer.sv
// lock_sequencer: session controller for the push-button digital lock.
// Collects bits (MSB first) into attempts, compares them against the
// programmable code register, runs the unlock window, the failed-attempt
// lockout and code re-programming while open.
//   clk_1hz : system tick, all state changes on its rising edge
//   reset   : asynchronous, active-high
//   bus     : lock_sequencer_if slave (button pulses in, status out)
module lock_sequencer #(
    parameter int                  CODE_LEN     = 5,
    parameter logic [CODE_LEN-1:0] DEFAULT_CODE = lock_pkg::DEFAULT_CODE,
    parameter int                  MAX_FAILS    = 3,
    parameter int                  OPEN_SEC     = 5,
    parameter int                  LOCKOUT_SEC  = 10,
    parameter int                  ENTRY_TO     = 8
) (
    input logic             clk_1hz,
    input logic             reset,
    lock_sequencer_if.slave bus
);
    import lock_pkg::*;

    localparam int            TW         = timer_width(OPEN_SEC, LOCKOUT_SEC, ENTRY_TO);
    localparam logic [TW-1:0] ENTRY_LOAD = TW'(ENTRY_TO);
    localparam logic [TW-1:0] OPEN_LOAD  = TW'(OPEN_SEC);
    localparam logic [TW-1:0] LOCK_LOAD  = TW'(LOCKOUT_SEC);

    lock_state_t         state, state_next;
    logic [CODE_LEN-1:0] code_reg, code_next;
    logic [CODE_LEN-2:0] entry_reg, entry_next;
    logic [2:0]          digit_reg, digit_next, digit_inc;
    logic [1:0]          fails_reg, fails_next;
    logic [2:0]          fails_inc;
    logic                unlock_reg, unlock_next;
    logic                alarm_reg, alarm_next;
    logic                tmr_load, tmr_expired;
    logic [TW-1:0]       tmr_load_val;
    logic                bit_event, bit_val, last_bit, code_match;
    logic [CODE_LEN-1:0] attempt;

    sec_timer #(.WIDTH(TW)) timer (
        .clk_1hz  (clk_1hz),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .expired  (tmr_expired)
    );

    // The entry register keeps only the earlier bits; the attempt is
    // completed with the bit arriving this cycle so the comparison and
    // unlock happen on the capturing edge itself.
    assign bit_event  = bus.bit_zero | bus.bit_one;
    assign bit_val    = bus.bit_one;
    assign attempt    = {entry_reg, bit_val};
    assign last_bit   = bit_event && (digit_reg == 3'(CODE_LEN - 1));
    assign code_match = (attempt == code_reg);
    assign digit_inc  = (digit_reg == 3'd7) ? 3'd7 : digit_reg + 3'd1;
    assign fails_inc  = {1'b0, fails_reg} + 3'd1;

    // State register together with every registered output.
    always_ff @(posedge clk_1hz or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            code_reg   <= DEFAULT_CODE;
            entry_reg  <= '0;
            digit_reg  <= '0;
            fails_reg  <= '0;
            unlock_reg <= 1'b0;
            alarm_reg  <= 1'b0;
        end else begin
            state      <= state_next;
            code_reg   <= code_next;
            entry_reg  <= entry_next;
            digit_reg  <= digit_next;
            fails_reg  <= fails_next;
            unlock_reg <= unlock_next;
            alarm_reg  <= alarm_next;
        end
    end

    // Next-state logic. A bit event outranks a timeout on the same edge,
    // and prog_req outranks the end of the unlock window.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (bit_event) state_next = ST_ENTRY;
            end
            ST_ENTRY: begin
                if (last_bit) begin
                    if (code_match)                          state_next = ST_OPEN;
                    else if (fails_inc >= 3'(MAX_FAILS))     state_next = ST_LOCKOUT;
                    else                                     state_next = ST_IDLE;
                end else if (!bit_event && tmr_expired) begin
                    state_next = ST_IDLE;
                end
            end
            ST_OPEN: begin
                if (bus.prog_req)     state_next = ST_PROG;
                else if (tmr_expired) state_next = ST_IDLE;
            end
            ST_PROG: begin
                if (last_bit)                         state_next = ST_IDLE;
                else if (!bit_event && tmr_expired)   state_next = ST_IDLE;
            end
            ST_LOCKOUT: begin
                if (tmr_expired) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, the code/entry registers and
    // the timer load, decided from the same conditions as the transition.
    always_comb begin
        code_next    = code_reg;
        entry_next   = entry_reg;
        digit_next   = digit_reg;
        fails_next   = fails_reg;
        unlock_next  = unlock_reg;
        alarm_next   = alarm_reg;
        tmr_load     = 1'b0;
        tmr_load_val = ENTRY_LOAD;
        case (state)
            ST_IDLE: begin
                if (bit_event) begin
                    entry_next    = '0;
                    entry_next[0] = bit_val;
                    digit_next    = 3'd1;
                    tmr_load      = 1'b1;
                end
            end
            ST_ENTRY: begin
                if (bit_event) begin
                    entry_next = attempt[CODE_LEN-2:0];
                    digit_next = digit_inc;
                    tmr_load   = 1'b1;
                    if (last_bit) begin
                        digit_next = '0;
                        if (code_match) begin
                            unlock_next  = 1'b1;
                            fails_next   = '0;
                            tmr_load_val = OPEN_LOAD;
                        end else if (fails_inc >= 3'(MAX_FAILS)) begin
                            alarm_next   = 1'b1;
                            fails_next   = '0;
                            tmr_load_val = LOCK_LOAD;
                        end else begin
                            fails_next = fails_inc[2] ? 2'd3 : fails_inc[1:0];
                        end
                    end
                end else if (tmr_expired) begin
                    digit_next = '0;
                end
            end
            ST_OPEN: begin
                if (bus.prog_req) begin
                    digit_next = '0;
                    tmr_load   = 1'b1;
                end else if (tmr_expired) begin
                    unlock_next = 1'b0;
                end
            end
            ST_PROG: begin
                if (bit_event) begin
                    entry_next = attempt[CODE_LEN-2:0];
                    digit_next = digit_inc;
                    tmr_load   = 1'b1;
                    if (last_bit) begin
                        code_next   = attempt;
                        digit_next  = '0;
                        unlock_next = 1'b0;
                    end
                end else if (tmr_expired) begin
                    digit_next  = '0;
                    unlock_next = 1'b0;
                end
            end
            ST_LOCKOUT: begin
                if (tmr_expired) alarm_next = 1'b0;
            end
            default: begin
                digit_next  = '0;
                fails_next  = '0;
                unlock_next = 1'b0;
                alarm_next  = 1'b0;
            end
        endcase
    end

    assign bus.unlock     = unlock_reg;
    assign bus.alarm      = alarm_reg;
    assign bus.state_code = state;
    assign bus.digit_cnt  = digit_reg;
    assign bus.fail_cnt   = fails_reg;
endmodule

// File: tb/tb_lock_sequencer.sv
// Testbench for lock_sequencer: a table of per-cycle vectors, hand-written
// multi-cycle sequences (programming, expiry-edge corners, async reset)
// and a randomized phase checked against a deadline-based lock model.
module tb_lock_sequencer;
    localparam int         CODE_LEN    = 5;
    localparam int         MAX_FAILS   = 3;
    localparam int         OPEN_SEC    = 5;
    localparam int         LOCKOUT_SEC = 10;
    localparam int         ENTRY_TO    = 8;
    localparam logic [4:0] RESET_CODE  = 5'b11011;

    localparam int M_IDLE = 0, M_ENTRY = 1, M_OPEN = 2, M_PROG = 3, M_LOCK = 4;

    typedef struct {
        logic       b0, b1, pr;
        logic       unl, al;
        logic [2:0] st, dg;
        logic [1:0] fl;
    } vec_t;

    logic clk_1hz;
    logic reset;
    int   tests_run    = 0;
    int   tests_failed = 0;
    vec_t vecs[$];

    // Reference lock: a mode, the bits typed so far, and the absolute
    // cycle number at which the current timed phase ends.
    int m_mode, m_fails, m_code, m_cyc, m_deadline;
    bit m_bits[$];

    lock_sequencer_if bus();

    lock_sequencer #(
        .CODE_LEN     (CODE_LEN),
        .DEFAULT_CODE (RESET_CODE),
        .MAX_FAILS    (MAX_FAILS),
        .OPEN_SEC     (OPEN_SEC),
        .LOCKOUT_SEC  (LOCKOUT_SEC),
        .ENTRY_TO     (ENTRY_TO)
    ) dut (
        .clk_1hz (clk_1hz),
        .reset   (reset),
        .bus     (bus)
    );

    initial clk_1hz = 1'b0;
    always #5 clk_1hz = ~clk_1hz;

    function automatic void modelReset();
        m_mode  = M_IDLE;
        m_fails = 0;
        m_code  = int'(RESET_CODE);
        m_bits.delete();
    endfunction

    function automatic int packBits();
        int v;
        v = 0;
        foreach (m_bits[i]) v = (v << 1) | int'(m_bits[i]);
        return v;
    endfunction

    function automatic void modelStep(input logic b0, input logic b1, input logic pr);
        bit ev;
        int val;
        ev = b0 | b1;
        m_cyc++;
        case (m_mode)
            M_IDLE: begin
                if (ev) begin
                    m_bits.delete();
                    m_bits.push_back(b1);
                    m_deadline = m_cyc + ENTRY_TO;
                    m_mode = M_ENTRY;
                end
            end
            M_ENTRY, M_PROG: begin
                if (ev) begin
                    m_bits.push_back(b1);
                    m_deadline = m_cyc + ENTRY_TO;
                    if (m_bits.size() == CODE_LEN) begin
                        val = packBits();
                        m_bits.delete();
                        if (m_mode == M_PROG) begin
                            m_code = val;
                            m_mode = M_IDLE;
                        end else if (val == m_code) begin
                            m_mode = M_OPEN;
                            m_fails = 0;
                            m_deadline = m_cyc + OPEN_SEC;
                        end else if (m_fails + 1 >= MAX_FAILS) begin
                            m_mode = M_LOCK;
                            m_fails = 0;
                            m_deadline = m_cyc + LOCKOUT_SEC;
                        end else begin
                            m_fails++;
                            m_mode = M_IDLE;
                        end
                    end
                end else if (m_cyc == m_deadline) begin
                    m_mode = M_IDLE;
                    m_bits.delete();
                end
            end
            M_OPEN: begin
                if (pr) begin
                    m_mode = M_PROG;
                    m_bits.delete();
                    m_deadline = m_cyc + ENTRY_TO;
                end else if (m_cyc == m_deadline) begin
                    m_mode = M_IDLE;
                end
            end
            M_LOCK: begin
                if (m_cyc == m_deadline) m_mode = M_IDLE;
            end
            default: m_mode = M_IDLE;
        endcase
    endfunction

    function automatic void addVec(input logic b0, input logic b1, input logic pr,
                                   input logic unl, input logic al, input logic [2:0] st,
                                   input logic [2:0] dg, input logic [1:0] fl);
        vec_t v;
        v.b0 = b0; v.b1 = b1; v.pr = pr;
        v.unl = unl; v.al = al; v.st = st; v.dg = dg; v.fl = fl;
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input logic b0, input logic b1, input logic pr);
        bus.bit_zero = b0;
        bus.bit_one  = b1;
        bus.prog_req = pr;
        @(posedge clk_1hz);
        modelStep(b0, b1, pr);
        #1;
        bus.bit_zero = 1'b0;
        bus.bit_one  = 1'b0;
        bus.prog_req = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic e_unl, input logic e_al,
                               input logic [2:0] e_st, input logic [2:0] e_dg,
                               input logic [1:0] e_fl);
        tests_run++;
        if (bus.unlock !== e_unl || bus.alarm !== e_al || bus.state_code !== e_st ||
            bus.digit_cnt !== e_dg || bus.fail_cnt !== e_fl) begin
            tests_failed++;
            $display("[TB] FAIL %s: got unlock=%0b alarm=%0b state_code=%0d digit_cnt=%0d fail_cnt=%0d, expected unlock=%0b alarm=%0b state_code=%0d digit_cnt=%0d fail_cnt=%0d",
                     name, bus.unlock, bus.alarm, bus.state_code, bus.digit_cnt, bus.fail_cnt,
                     e_unl, e_al, e_st, e_dg, e_fl);
        end
    endtask

    task automatic checkModel(input string name);
        checkOutput(name, (m_mode == M_OPEN) || (m_mode == M_PROG), m_mode == M_LOCK,
                    3'(m_mode), 3'(m_bits.size()), 2'(m_fails));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic enterCode(input logic [4:0] c);
        for (int i = 4; i >= 0; i--) applyStimulus(!c[i], c[i], 1'b0);
    endtask

    // Reset pulse placed mid-cycle; outputs must clear without a clock edge.
    task automatic asyncReset(input string name);
        #3;
        reset = 1'b1;
        modelReset();
        #1;
        checkOutput(name, 1'b0, 1'b0, 3'd0, 3'd0, 2'd0);
        #1;
        reset = 1'b0;
    endtask

    task automatic randCycle(input logic b0, input logic b1, input logic pr);
        applyStimulus(b0, b1, pr);
        checkModel("random cycle");
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [4:0] c;
        int         kind, n, r;

        reset = 1'b1;
        bus.bit_zero = 1'b0;
        bus.bit_one  = 1'b0;
        bus.prog_req = 1'b0;
        m_cyc = 0;
        m_deadline = 0;
        modelReset();

        // Correct code 1,1,0,1,1 and the five-cycle unlock window.
        addVec(0,1,0, 0,0,1,1,0); addVec(0,1,0, 0,0,1,2,0); addVec(1,0,0, 0,0,1,3,0);
        addVec(0,1,0, 0,0,1,4,0); addVec(0,1,0, 1,0,2,0,0);
        for (int i = 0; i < 4; i++) addVec(0,0,0, 1,0,2,0,0);
        addVec(0,0,0, 0,0,0,0,0);
        // Two wrong attempts 1,0,0,0,0.
        for (int a = 0; a < 2; a++) begin
            addVec(0,1,0, 0,0,1,1,2'(a)); addVec(1,0,0, 0,0,1,2,2'(a));
            addVec(1,0,0, 0,0,1,3,2'(a)); addVec(1,0,0, 0,0,1,4,2'(a));
            addVec(1,0,0, 0,0,0,0,2'(a + 1));
        end
        // Partial entry abandoned after eight idle cycles; fail count kept.
        addVec(0,1,0, 0,0,1,1,2); addVec(0,1,0, 0,0,1,2,2);
        for (int i = 0; i < 7; i++) addVec(0,0,0, 0,0,1,2,2);
        addVec(0,0,0, 0,0,0,0,2);
        addVec(0,0,1, 0,0,0,0,2);
        // Correct code with both buttons on the second bit; bits in OPEN ignored.
        addVec(0,1,0, 0,0,1,1,2); addVec(1,1,0, 0,0,1,2,2); addVec(1,0,0, 0,0,1,3,2);
        addVec(0,1,0, 0,0,1,4,2); addVec(0,1,0, 1,0,2,0,0);
        addVec(0,1,0, 1,0,2,0,0);
        for (int i = 0; i < 3; i++) addVec(0,0,0, 1,0,2,0,0);
        addVec(0,0,0, 0,0,0,0,0);
        // Three wrong attempts into a ten-cycle lockout that ignores inputs.
        for (int a = 0; a < 3; a++) begin
            addVec(0,1,0, 0,0,1,1,2'(a)); addVec(1,0,0, 0,0,1,2,2'(a));
            addVec(1,0,0, 0,0,1,3,2'(a)); addVec(1,0,0, 0,0,1,4,2'(a));
            if (a < 2) addVec(1,0,0, 0,0,0,0,2'(a + 1));
            else       addVec(1,0,0, 0,1,4,0,0);
        end
        addVec(0,1,0, 0,1,4,0,0); addVec(1,0,0, 0,1,4,0,0);
        addVec(0,0,1, 0,1,4,0,0); addVec(1,1,0, 0,1,4,0,0);
        for (int i = 0; i < 5; i++) addVec(0,0,0, 0,1,4,0,0);
        addVec(0,0,0, 0,0,0,0,0);

        #12;
        checkOutput("reset state", 1'b0, 1'b0, 3'd0, 3'd0, 2'd0);
        #1;
        reset = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].b0, vecs[i].b1, vecs[i].pr);
            checkOutput($sformatf("vector %0d", i), vecs[i].unl, vecs[i].al,
                        vecs[i].st, vecs[i].dg, vecs[i].fl);
        end

        // A bit on the timeout edge is captured instead of timing out.
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("first bit", 1'b0, 1'b0, 3'd1, 3'd1, 2'd0);
        idle(7);
        checkOutput("entry before expiry", 1'b0, 1'b0, 3'd1, 3'd1, 2'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("bit on expiry edge", 1'b0, 1'b0, 3'd1, 3'd2, 2'd0);
        idle(7);
        checkOutput("entry held", 1'b0, 1'b0, 3'd1, 3'd2, 2'd0);
        idle(1);
        checkOutput("entry timeout", 1'b0, 1'b0, 3'd0, 3'd0, 2'd0);

        // Re-program to 0,1,0,1,0 and check old and new codes.
        enterCode(5'b11011);
        checkOutput("unlock default code", 1'b1, 1'b0, 3'd2, 3'd0, 2'd0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("enter prog", 1'b1, 1'b0, 3'd3, 3'd0, 2'd0);
        for (int i = 0; i < 4; i++) applyStimulus(i % 2 == 0, i % 2 == 1, 1'b0);
        checkOutput("prog four bits", 1'b1, 1'b0, 3'd3, 3'd4, 2'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("prog done", 1'b0, 1'b0, 3'd0, 3'd0, 2'd0);
        enterCode(5'b11011);
        checkOutput("old code rejected", 1'b0, 1'b0, 3'd0, 3'd0, 2'd1);
        enterCode(5'b01010);
        checkOutput("new code accepted", 1'b1, 1'b0, 3'd2, 3'd0, 2'd0);

        // prog_req on the last open cycle, then a programming timeout.
        idle(4);
        checkOutput("open last cycle", 1'b1, 1'b0, 3'd2, 3'd0, 2'd0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("prog on final cycle", 1'b1, 1'b0, 3'd3, 3'd0, 2'd0);
        idle(7);
        checkOutput("prog waiting", 1'b1, 1'b0, 3'd3, 3'd0, 2'd0);
        idle(1);
        checkOutput("prog timeout", 1'b0, 1'b0, 3'd0, 3'd0, 2'd0);
        enterCode(5'b01010);
        checkOutput("code kept after timeout", 1'b1, 1'b0, 3'd2, 3'd0, 2'd0);

        // Reset in the middle of programming reverts the code.
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("mid prog", 1'b1, 1'b0, 3'd3, 3'd2, 2'd0);
        asyncReset("reset mid prog");
        enterCode(5'b11011);
        checkOutput("default code restored", 1'b1, 1'b0, 3'd2, 3'd0, 2'd0);

        // Reset in the middle of lockout.
        idle(5);
        checkOutput("window closed", 1'b0, 1'b0, 3'd0, 3'd0, 2'd0);
        enterCode(5'b10000);
        enterCode(5'b10000);
        checkOutput("two fails", 1'b0, 1'b0, 3'd0, 3'd0, 2'd2);
        enterCode(5'b10000);
        checkOutput("lockout", 1'b0, 1'b1, 3'd4, 3'd0, 2'd0);
        idle(3);
        checkOutput("lockout held", 1'b0, 1'b1, 3'd4, 3'd0, 2'd0);
        asyncReset("reset mid lockout");
        enterCode(5'b11011);
        checkOutput("unlock after reset", 1'b1, 1'b0, 3'd2, 3'd0, 2'd0);
        idle(5);

        // Randomized sessions against the reference model.
        for (int burst = 0; burst < 300; burst++) begin
            kind = $urandom_range(0, 5);
            case (kind)
                0, 1: begin
                    c = 5'(m_code);
                    for (int i = 4; i >= 0; i--) begin
                        n = $urandom_range(0, 2);
                        for (int g = 0; g < n; g++) randCycle(1'b0, 1'b0, 1'b0);
                        randCycle(!c[i], c[i], 1'b0);
                    end
                end
                2: begin
                    n = $urandom_range(1, 7);
                    for (int i = 0; i < n; i++) begin
                        r = $urandom_range(0, 3);
                        randCycle(r[0], r[1], 1'b0);
                    end
                end
                3: randCycle(1'b0, 1'b0, 1'b1);
                4: begin
                    n = $urandom_range(1, 12);
                    for (int i = 0; i < n; i++) randCycle(1'b0, 1'b0, $urandom_range(0, 7) == 0);
                end
                default: begin
                    if ($urandom_range(0, 4) == 0) asyncReset("random reset");
                    else randCycle(1'b0, 1'b0, 1'b0);
                end
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/lock_sequencer.md
# lock_sequencer

Session controller for the push-button digital lock. It sits downstream of the per-button synchronizer and level-to-pulse stages and upstream of the seven-segment decoder. It collects entered bits into fixed-length attempts and compares each attempt against a programmable code register. It drives a timed unlock window, counts failed attempts into a timed lockout, and lets the code be re-programmed while the lock is open.

## Interface
Parameters:
- CODE_LEN, 5: bits per attempt (2..7).
- DEFAULT_CODE, 5'b11011: code loaded on reset; width CODE_LEN.
- MAX_FAILS, 3: consecutive failed attempts that trigger lockout (1..3).
- OPEN_SEC, 5: unlock window length, in clk_1hz cycles.
- LOCKOUT_SEC, 10: lockout length, in clk_1hz cycles.
- ENTRY_TO, 8: idle cycles allowed between bits before a partial attempt is abandoned.

Ports:
- clk_1hz  in  1  system tick; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clock clk_1hz.
- bit_zero  in  1  one-cycle pulse; operator entered 0.
- bit_one  in  1  one-cycle pulse; operator entered 1.
- prog_req  in  1  one-cycle pulse; request code re-programming.
- unlock  out  1  lock actuator enable.
- alarm  out  1  high for the whole lockout period.
- state_code  out  3  current state encoding, for the seven-segment decoder.
- digit_cnt  out  3  bits captured in the current attempt or programming pass.
- fail_cnt  out  2  consecutive failed attempts.

## Operation
- Bit event: bit_zero or bit_one is high on an edge. When both are high, the bit value is 1 (bit_one wins).
- Entry order: first bit entered is the MSB. Each new bit shifts into the entry register from the LSB.
- States and encodings: IDLE=0, ENTRY=1, OPEN=2, PROG=3, LOCKOUT=4. Encodings 5..7 are illegal and go to IDLE with all outputs cleared.
- IDLE:
  - Bit event: capture bit, digit_cnt=1, load timer with ENTRY_TO, go to ENTRY.
  - prog_req: ignored.
- ENTRY:
  - Bit event: shift, digit_cnt+1, reload timer with ENTRY_TO.
  - On the CODE_LEN-th bit, compare the full value (including the bit just captured) against the code register.
  - Match: go to OPEN; unlock=1, fail_cnt=0, timer=OPEN_SEC.
  - Mismatch with fail_cnt+1 < MAX_FAILS: fail_cnt+1, go to IDLE.
  - Mismatch with fail_cnt+1 == MAX_FAILS: go to LOCKOUT; alarm=1, fail_cnt=0, timer=LOCKOUT_SEC.
  - Timer expires with no bit event: go to IDLE, digit_cnt=0, fail_cnt unchanged.
- OPEN:
  - unlock=1; bit events ignored.
  - prog_req: go to PROG, digit_cnt=0, timer=ENTRY_TO; unlock stays 1.
  - Timer expires: go to IDLE, unlock=0.
- PROG:
  - Bits are captured as in ENTRY.
  - On the CODE_LEN-th bit, the code register takes the new value; go to IDLE, unlock=0.
  - Timeout: go to IDLE with the code unchanged.
- LOCKOUT:
  - alarm=1; all bit events and prog_req ignored.
  - Timer expires: go to IDLE, alarm=0.
- digit_cnt clears on every entry into IDLE, OPEN and LOCKOUT.
- Arithmetic: timer is a down-counter wide enough for the largest parameter. digit_cnt and fail_cnt saturate and never wrap.

## Timing
- Reset values: state=IDLE, code register=DEFAULT_CODE, unlock=0, alarm=0, state_code=0, digit_cnt=0, fail_cnt=0, timer=0.
- Reset mid-operation: takes effect immediately, asynchronously. A programmed code is lost and the register reverts to DEFAULT_CODE.
- All outputs are registered and change only on the edge that makes the state transition.
- Unlock window: unlock rises on the edge that captures the last correct bit and stays high for exactly OPEN_SEC cycles.
- Lockout: alarm stays high for exactly LOCKOUT_SEC cycles.
- Entry timeout: fires ENTRY_TO cycles after the last bit event.
- A bit event on the expiry cycle counts as a bit; it wins over the timeout.
- prog_req on the final OPEN cycle is honoured: go to PROG.
- Latency from last bit pulse to unlock: 0 cycles relative to the capturing edge.

## Structure
- Package lock_pkg holds:
  - state encoding constants;
  - DEFAULT_CODE;
  - the timer width function (clog2 of the largest timer parameter plus 1).
- Sub-module sec_timer: a loadable down-counter with load, load_val and expired outputs. It is shared by the OPEN, LOCKOUT and timeout paths.
- Inputs are already synchronized one-cycle pulses from the existing synchronizer and level-to-pulse stages. This block does no synchronization.

## Test plan
- After reset, enter 1,1,0,1,1 → unlock=1 from the 5th-bit edge for 5 cycles; state_code 2 then 0; fail_cnt=0.
- Enter 1,0,0,0,0 three times → fail_cnt goes 1, 2; on the 3rd attempt alarm=1 and state_code=4 for 10 cycles. Bit pulses during lockout produce no change.
- Enter 1,1 then wait 8 idle cycles → IDLE, digit_cnt=0, fail_cnt unchanged. Then enter 1,1,0,1,1 → unlock.
- Unlock, pulse prog_req, enter 0,1,0,1,0 → code=5'b01010. Entering 1,1,0,1,1 now fails; entering 0,1,0,1,0 unlocks.
- bit_zero and bit_one high together on an edge → bit captured as 1.
- Assert reset mid-PROG and mid-LOCKOUT → all outputs 0 immediately; code reverts to 5'b11011.
